// File: rtl/deinterleaver.sv
// Receive-side PUSCH bit deinterleaver.
// Collects E elements that arrive column-major in a Qm-column matrix, then replays them row-major.
// One codeword is in flight at a time, moving through IDLE -> CALC -> FILL -> DRAIN.
module deinterleaver #(
  parameter int unsigned MAX_E = 93996,
  parameter int unsigned DW    = 1,
  parameter int unsigned AW    = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [16:0]   E,
  input  logic [2:0]    Qm,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  output logic          ready_in,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          last_out,
  output logic          busy,
  output logic          err
);

  localparam logic [16:0] MaxE = 17'(MAX_E);

  typedef enum logic [1:0] {StIdle, StCalc, StFill, StDrain} state_e;

  state_e        state_q;
  logic [16:0]   e_q;
  logic [2:0]    qm_q;
  // R equals E when Qm=1, so the row count and row index carry the full element width.
  logic [16:0]   r_q;
  logic [16:0]   wr_row_q;
  logic [2:0]    wr_col_q;
  logic [AW-1:0] wr_addr_q;
  logic [16:0]   in_cnt_q;
  logic [AW-1:0] rd_addr_q;
  logic          rd_done_q;

  // Restoring divide-by-3 state used only for Qm=6.
  logic [16:0]   dvd_q;
  logic [1:0]    rem_q;
  logic [4:0]    div_cnt_q;

  logic [DW-1:0] mem_q [0:MAX_E-1];

  logic          start_ok;
  logic          shape_ok;
  logic [2:0]    div_trial;
  logic          div_bit;
  logic [1:0]    div_rem;
  logic [16:0]   div_quot;
  logic          calc_last;
  logic          calc_fail;
  logic [16:0]   r_calc;
  logic          accept;
  logic          in_last;
  logic          row_wrap;
  logic          rd_last;

  // Decide whether a start request describes a codeword we can handle.
  always_comb begin
    shape_ok = 1'b0;
    case (Qm)
      3'd1:    shape_ok = 1'b1;
      3'd2:    shape_ok = ~E[0];
      3'd4:    shape_ok = (E[1:0] == 2'b00);
      // Divisibility by 3 is only known once the CALC divider finishes.
      3'd6:    shape_ok = ~E[0];
      default: shape_ok = 1'b0;
    endcase
    start_ok = shape_ok && (E != 17'd0) && (E <= MaxE);
  end

  // One restoring-division step of (E/2)/3, plus the per-Qm row count.
  always_comb begin
    div_trial = {rem_q, dvd_q[16]};
    div_bit   = (div_trial >= 3'd3);
    div_rem   = div_bit ? 2'(div_trial - 3'd3) : div_trial[1:0];
    div_quot  = {dvd_q[15:0], div_bit};
    calc_last = (qm_q != 3'd6) || (div_cnt_q == 5'd16);
    calc_fail = (qm_q == 3'd6) && (div_cnt_q == 5'd16) && (div_rem != 2'd0);
    case (qm_q)
      3'd1:    r_calc = e_q;
      3'd2:    r_calc = e_q >> 1;
      3'd4:    r_calc = e_q >> 2;
      default: r_calc = div_quot;
    endcase
  end

  // Input handshake and address-walk decisions.
  always_comb begin
    accept   = valid_in & ready_in;
    in_last  = (in_cnt_q == e_q - 17'd1);
    row_wrap = (wr_row_q == r_q - 17'd1);
    rd_last  = (rd_addr_q == AW'(e_q - 17'd1));
  end

  // Buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_addr_q] <= data_in;
    end
  end

  // Control FSM with registered outputs and the registered buffer read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      e_q       <= '0;
      qm_q      <= '0;
      r_q       <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_addr_q <= '0;
      in_cnt_q  <= '0;
      rd_addr_q <= '0;
      rd_done_q <= 1'b0;
      dvd_q     <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      ready_in  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              e_q       <= E;
              qm_q      <= Qm;
              dvd_q     <= {1'b0, E[16:1]};
              rem_q     <= 2'd0;
              div_cnt_q <= 5'd0;
              busy      <= 1'b1;
              state_q   <= StCalc;
            end else begin
              err <= 1'b1;
            end
          end
        end

        StCalc: begin
          if (qm_q == 3'd6) begin
            dvd_q     <= div_quot;
            rem_q     <= div_rem;
            div_cnt_q <= div_cnt_q + 5'd1;
          end
          if (calc_fail) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (calc_last) begin
            r_q       <= r_calc;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_addr_q <= '0;
            in_cnt_q  <= '0;
            ready_in  <= 1'b1;
            state_q   <= StFill;
          end
        end

        StFill: begin
          if (accept) begin
            in_cnt_q <= in_cnt_q + 17'd1;
            if (in_last) begin
              // Leave the walk untouched so the column never steps past Qm-1.
              ready_in  <= 1'b0;
              rd_addr_q <= '0;
              rd_done_q <= 1'b0;
              state_q   <= StDrain;
            end else if (row_wrap) begin
              wr_row_q  <= '0;
              wr_col_q  <= wr_col_q + 3'd1;
              wr_addr_q <= AW'(wr_col_q) + AW'(1);
            end else begin
              wr_row_q  <= wr_row_q + 17'd1;
              wr_addr_q <= wr_addr_q + AW'(qm_q);
            end
          end
        end

        StDrain: begin
          if (!rd_done_q) begin
            data_out  <= mem_q[rd_addr_q];
            valid_out <= 1'b1;
            last_out  <= rd_last;
            if (rd_last) begin
              rd_done_q <= 1'b1;
            end else begin
              rd_addr_q <= rd_addr_q + AW'(1);
            end
          end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

  // The write walk must stay inside the codeword and inside the Qm columns.
  wr_addr_in_range: assert property (@(posedge clk) disable iff (!reset)
    (state_q == StFill) |-> ((32'(wr_addr_q) < 32'(e_q)) && (wr_col_q < qm_q)));

endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for deinterleaver: expected elements are queued as stimulus is driven
// and popped as the DUT emits them.
module tb_deinterleaver;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [16:0]   E = '0;
  logic [2:0]    Qm = '0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          last_out;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat [64];
  logic [7:0] exp_q [$];

  deinterleaver #(.MAX_E(93996), .DW(DW), .AW(17)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .E        (E),
    .Qm       (Qm),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .last_out (last_out),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic start_cw(input int e, input int qm);
    @(posedge clk); #1;
    start = 1'b1;
    E     = 17'(e);
    Qm    = 3'(qm);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count CALC cycles until ready_in rises; leaves the bench at a negedge with ready_in high.
  task automatic wait_fill(input int exp_calc, input string name);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (ready_in === 1'b1) break;
      n++;
    end
    checks++;
    if (n !== exp_calc) begin
      errors++;
      $display("FAIL %s calc_cycles: got %0d expected %0d", name, n, exp_calc);
    end
  endtask

  // Drive column-major input built from pat (pat holds the row-major result) and queue the result.
  task automatic feed(input int e, input int qm, input bit gaps);
    int r = e / qm;
    for (int j = 0; j < e; j++) exp_q.push_back(pat[j]);
    for (int k = 0; k < e; k++) begin
      valid_in = 1'b1;
      data_in  = pat[(k % r) * qm + k / r];
      @(posedge clk); #1;
      if (gaps && k != e - 1) begin
        valid_in = 1'b0;
        data_in  = 8'hEE;
        @(posedge clk); #1;
      end
    end
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  // Called just after the last input is accepted; checks latency, contents, last_out and wind-down.
  task automatic drain_check(input int e, input string name);
    int lat;
    logic [7:0] exp;
    logic exp_last;
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_drop: ready_in=%0b busy=%0b expected ready_in=0 busy=1",
               name, ready_in, busy);
    end
    lat = 1;
    while (valid_out !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 2", name, lat);
    end
    for (int i = 0; i < e; i++) begin
      if (i > 0) @(negedge clk);
      exp      = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      exp_last = (i == e - 1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp || last_out !== exp_last) begin
        errors++;
        $display("FAIL %s out[%0d]: valid=%0b data=%0h last=%0b expected valid=1 data=%0h last=%0b",
                 name, i, valid_out, data_out, last_out, exp, exp_last);
      end
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || last_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s wind_down: valid=%0b last=%0b busy=%0b expected all 0",
               name, valid_out, last_out, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({ready_in, valid_out, last_out, busy, err} !== 5'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b valid=%0b last=%0b busy=%0b err=%0b data=%0h expected 0",
               ready_in, valid_out, last_out, busy, err, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready_in, valid_out, busy, err} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%0b valid=%0b busy=%0b err=%0b expected 0",
               ready_in, valid_out, busy, err);
    end
  endtask

  task automatic test_qm2();
    for (int j = 0; j < 8; j++) pat[j] = 8'(j);
    start_cw(8, 2);
    wait_fill(1, "qm2");
    feed(8, 2, 1'b0);
    drain_check(8, "qm2");
  endtask

  task automatic test_qm6();
    for (int j = 0; j < 12; j++) pat[j] = 8'(j);
    start_cw(12, 6);
    wait_fill(17, "qm6");
    feed(12, 6, 1'b0);
    drain_check(12, "qm6");
  endtask

  task automatic test_qm1();
    pat[0] = 8'd1; pat[1] = 8'd0; pat[2] = 8'd1; pat[3] = 8'd1; pat[4] = 8'd0;
    start_cw(5, 1);
    wait_fill(1, "qm1");
    feed(5, 1, 1'b0);
    drain_check(5, "qm1");
  endtask

  task automatic test_gaps();
    for (int j = 0; j < 8; j++) pat[j] = 8'(j);
    start_cw(8, 4);
    wait_fill(1, "gaps");
    feed(8, 4, 1'b1);
    drain_check(8, "gaps");
  endtask

  task automatic test_random();
    for (int j = 0; j < 48; j++) pat[j] = 8'($urandom_range(0, 255));
    start_cw(48, 6);
    wait_fill(17, "rand_qm6");
    feed(48, 6, 1'b0);
    drain_check(48, "rand_qm6");
    for (int j = 0; j < 40; j++) pat[j] = 8'($urandom_range(0, 255));
    start_cw(40, 4);
    wait_fill(1, "rand_qm4");
    feed(40, 4, 1'b0);
    drain_check(40, "rand_qm4");
  endtask

  task automatic test_illegal();
    int cases_e [5]  = '{10, 10, 0, 13, 100000};
    int cases_qm [5] = '{3, 4, 2, 6, 1};
    int n;
    for (int i = 0; i < 5; i++) begin
      start_cw(cases_e[i], cases_qm[i]);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || ready_in !== 1'b0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d pulse: err=%0b busy=%0b ready=%0b valid=%0b expected 1 0 0 0",
                 i, err, busy, ready_in, valid_out);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d after: err=%0b busy=%0b valid=%0b expected 0",
                 i, err, busy, valid_out);
      end
    end
    // E=14, Qm=6 passes the start checks and fails on the divider remainder.
    start_cw(14, 6);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (err === 1'b1) break;
      if (ready_in !== 1'b0 || valid_out !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL illegal_e14 calc: ready=%0b valid=%0b expected 0", ready_in, valid_out);
      end
      n++;
    end
    checks++;
    if (n !== 17 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_e14 err: after %0d cycles busy=%0b expected 17 cycles busy=0", n, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL illegal_e14 after: err=%0b busy=%0b valid=%0b expected 0",
               err, busy, valid_out);
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 12; j++) pat[j] = 8'(j + 100);
    start_cw(12, 6);
    wait_fill(17, "mid");
    for (int k = 0; k < 5; k++) begin
      valid_in = 1'b1;
      data_in  = pat[(k % 2) * 6 + k / 2];
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if ({ready_in, valid_out, last_out, busy, err} !== 5'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL mid_reset: ready=%0b valid=%0b last=%0b busy=%0b err=%0b data=%0h expected 0",
               ready_in, valid_out, last_out, busy, err, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: valid=%0b busy=%0b expected 0", valid_out, busy);
    end
    for (int j = 0; j < 16; j++) pat[j] = 8'($urandom_range(0, 255));
    start_cw(16, 2);
    wait_fill(1, "post_reset");
    feed(16, 2, 1'b0);
    drain_check(16, "post_reset");
  endtask

  initial begin
    test_reset();
    test_qm2();
    test_qm6();
    test_qm1();
    test_gaps();
    test_random();
    test_illegal();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
